s_pl_ctrl: RTL

Elastic pipeline controller: sequences a chain of DEPTH synchronous pipeline register stages, SIZE bits wide, under a valid/ready handshake. It generates per-stage load enables so that bubbles collapse and back-pressure stalls only the stages that must hold. It also supports a synchronous flush and reports occupancy. It sits between any producer/consumer pair in the datapath that needs registered retiming with flow control.

---
 rtl/s_pl_ctrl_if.sv | 22 ++
 rtl/s_pl_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/s_pl_ctrl_if.sv
// Valid/ready stream bundle for s_pl_ctrl: upstream (i_vld/o_rdy/idat) and downstream (o_vld/i_rdy/odat).
// The slave modport is the controller side; the master modport is the producer/consumer side.
interface s_pl_ctrl_if #(
  parameter int SIZE = 8
);
  logic            i_vld;
  logic            o_rdy;
  logic [SIZE-1:0] idat;
  logic            o_vld;
  logic            i_rdy;
  logic [SIZE-1:0] odat;

  modport master (
    output i_vld, idat, i_rdy,
    input  o_rdy, o_vld, odat
  );

  modport slave (
    input  i_vld, idat, i_rdy,
    output o_rdy, o_vld, odat
  );
endinterface

// File: rtl/s_pl_ctrl.sv
// Elastic pipeline controller: DEPTH register stages with bubble collapse, flush and occupancy count.
// Optional feature macro S_PL_CTRL_SKID_EN adds a one-entry skid ahead of stage 0 (registered o_rdy).
module s_pl_ctrl #(
  parameter int              SIZE    = 8,
  parameter int              DEPTH   = 3,
  parameter logic [SIZE-1:0] RST_VAL = '0,
  parameter int              CW      = $clog2(DEPTH + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  s_pl_ctrl_if.slave    bus,
  output logic [CW-1:0] cnt
);

  logic [DEPTH-1:0] vld_reg;
  logic [DEPTH-1:0] vld_next;
  logic [SIZE-1:0]  dat_reg  [DEPTH];
  logic [SIZE-1:0]  dat_next [DEPTH];
  logic [DEPTH:0]   acc;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic             in_xfer;
  logic             src0_vld;
  logic [SIZE-1:0]  src0_dat;

  // acc[k]: stage k may load this cycle (it is empty, or its content moves on)
  always_comb begin
    acc[DEPTH] = bus.i_rdy;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc[k] = !vld_reg[k] | acc[k+1];
    end
  end

`ifdef S_PL_CTRL_SKID_EN
  logic            skid_vld_reg;
  logic            skid_vld_next;
  logic [SIZE-1:0] skid_dat_reg;
  logic [SIZE-1:0] skid_dat_next;

  // Ready depends only on skid state, so i_rdy never reaches o_rdy combinationally
  assign bus.o_rdy = !skid_vld_reg & !flush;
  assign in_xfer   = bus.i_vld & bus.o_rdy;
  assign src0_vld  = skid_vld_reg | in_xfer;
  assign src0_dat  = skid_vld_reg ? skid_dat_reg : bus.idat;

  always_comb begin
    skid_vld_next = skid_vld_reg;
    skid_dat_next = skid_dat_reg;
    if (flush) begin
      skid_vld_next = 1'b0;
      skid_dat_next = RST_VAL;
    end else if (skid_vld_reg) begin
      skid_vld_next = !acc[0];
    end else if (in_xfer && !acc[0]) begin
      skid_vld_next = 1'b1;
      skid_dat_next = bus.idat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld_reg <= 1'b0;
      skid_dat_reg <= RST_VAL;
    end else begin
      skid_vld_reg <= skid_vld_next;
      skid_dat_reg <= skid_dat_next;
    end
  end
`else
  assign bus.o_rdy = acc[0] & !flush;
  assign in_xfer   = bus.i_vld & bus.o_rdy;
  assign src0_vld  = in_xfer;
  assign src0_dat  = bus.idat;
`endif

  // Per-stage next state: a stage loads its source's valid, data only on a real word
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic            s_vld;
      logic [SIZE-1:0] s_dat;
      if (gi == 0) begin : g_head
        assign s_vld = src0_vld;
        assign s_dat = src0_dat;
      end else begin : g_body
        assign s_vld = vld_reg[gi-1];
        assign s_dat = dat_reg[gi-1];
      end
      assign vld_next[gi] = flush ? 1'b0 : (acc[gi] ? s_vld : vld_reg[gi]);
      assign dat_next[gi] = flush ? RST_VAL : ((acc[gi] && s_vld) ? s_dat : dat_reg[gi]);
    end
  endgenerate

  always_comb begin
    cnt_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_next = cnt_next + CW'(vld_next[k]);
    end
`ifdef S_PL_CTRL_SKID_EN
    cnt_next = cnt_next + CW'(skid_vld_next);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_reg <= '0;
      cnt_reg <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dat_reg[k] <= RST_VAL;
      end
    end else begin
      vld_reg <= vld_next;
      cnt_reg <= cnt_next;
      for (int k = 0; k < DEPTH; k++) begin
        dat_reg[k] <= dat_next[k];
      end
    end
  end

  assign bus.o_vld = vld_reg[DEPTH-1];
  assign bus.odat  = dat_reg[DEPTH-1];
  assign cnt       = cnt_reg;

endmodule
